// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store on an internal word array, answered LAT cycles later.
// Optional build macro MEM_BYTE_STRB_EN enables byte-strobed stores (req_wstrb); otherwise stores write full words.
module data_mem_responder #(
    parameter int W     = 32,
    parameter int DEPTH = 32,
    parameter int LAT   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [W-1:0]   req_addr,
    input  logic [W-1:0]   req_wdata,
    input  logic [W/8-1:0] req_wstrb,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_rdata,
    output logic           rsp_err,
    output logic           busy
);

    localparam int NB = W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [3:0]     cnt_r;
    logic           we_r;
    logic [W-1:0]   addr_r;
    logic [W-1:0]   wdata_r;
    logic           we_s;
    logic [W-1:0]   addr_s;
    logic [W-1:0]   wdata_s;
    logic           accept_s;
    logic           commit_s;
    logic           err_s;
    logic [IW-1:0]  idx_s;
    logic           req_ready_r;
    logic           rsp_valid_r;
    logic           busy_r;
    logic [W-1:0]   rsp_rdata_r;
    logic           rsp_err_r;
    logic [W-1:0]   rsp_rdata_nxt_s;
    logic           rsp_err_nxt_s;

    // Storage survives reset; only the power-up image is zero.
    logic [W-1:0]   mem_r [DEPTH] = '{default: '0};

`ifdef MEM_BYTE_STRB_EN
    logic [NB-1:0]  wstrb_r;
    logic [NB-1:0]  wstrb_s;
`else
    logic           unused_wstrb_s;
    assign unused_wstrb_s = ^req_wstrb;
`endif

    assign accept_s = (state_r == ST_IDLE) && req_valid;
    // With LAT=1 the commit edge is the acceptance edge, so live request fields are used; rst gates it off during reset.
    assign commit_s = rst && ((accept_s && (LAT == 1)) || ((state_r == ST_WAIT) && (cnt_r == 4'd1)));

    // Select the request fields for the commit: live in IDLE, latched afterwards.
    always_comb begin
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
`ifdef MEM_BYTE_STRB_EN
        wstrb_s = wstrb_r;
`endif
        if (state_r == ST_IDLE) begin
            we_s    = req_we;
            addr_s  = req_addr;
            wdata_s = req_wdata;
`ifdef MEM_BYTE_STRB_EN
            wstrb_s = req_wstrb;
`endif
        end else begin
            we_s    = we_r;
            addr_s  = addr_r;
            wdata_s = wdata_r;
`ifdef MEM_BYTE_STRB_EN
            wstrb_s = wstrb_r;
`endif
        end
    end

    assign err_s = (addr_s[1:0] != 2'b00) || ((addr_s >> 2) >= W'(DEPTH));
    assign idx_s = addr_s[IW+1:2];

    // Request capture at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
`ifdef MEM_BYTE_STRB_EN
            wstrb_r <= '0;
`endif
        end else if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
`ifdef MEM_BYTE_STRB_EN
            wstrb_r <= req_wstrb;
`endif
        end
    end

    // Latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= 4'(LAT - 1);
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Word array write port.
    always_ff @(posedge clk) begin
        if (commit_s && !err_s && we_s) begin
`ifdef MEM_BYTE_STRB_EN
            for (int b = 0; b < NB; b++) begin
                if (wstrb_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
`else
            mem_r[idx_s] <= wdata_s;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = (LAT == 1) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Response payload next values: loaded on commit, error cleared on handshake, otherwise held.
    always_comb begin
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
        if (commit_s) begin
            if (err_s) begin
                rsp_rdata_nxt_s = '0;
                rsp_err_nxt_s   = 1'b1;
            end else if (we_s) begin
                rsp_rdata_nxt_s = '0;
                rsp_err_nxt_s   = 1'b0;
            end else begin
                rsp_rdata_nxt_s = mem_r[idx_s];
                rsp_err_nxt_s   = 1'b0;
            end
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_err_nxt_s = 1'b0;
        end else begin
            rsp_err_nxt_s = rsp_err_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            busy_r      <= (state_nxt_s != ST_IDLE);
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 uses LAT=2, instance 1 uses LAT=1.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    data_mem_responder #(.W(32), .DEPTH(32), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    data_mem_responder #(.W(32), .DEPTH(32), .LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_v [2] = '{1'b0, 1'b0};

`ifdef MEM_BYTE_STRB_EN
    localparam logic [31:0] EXP_STRB  = 32'hAA22CC44;
    localparam logic [31:0] EXP_ZSTRB = 32'hAA22CC44;
`else
    localparam logic [31:0] EXP_STRB  = 32'h11223344;
    localparam logic [31:0] EXP_ZSTRB = 32'h99999999;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented response with the scoreboard head, pops on handshake.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i]) begin
                chk("req_ready_low_in_resp", {31'd0, req_ready[i]}, 32'd0);
                chk("busy_in_resp", {31'd0, busy[i]}, 32'd1);
                if (sbq.size() == 0 || sbq[0].inst != i) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp inst=%0d actual=%h required=none", i, rsp_rdata[i]);
                end else begin
                    // Consumer samples rsp_valid first at edge acc+LAT.
                    if (!prev_v[i]) chk("latency", cyc, sbq[0].acc + lat_of(i) - 1);
                    chk("rsp_rdata", rsp_rdata[i], sbq[0].rdata);
                    chk("rsp_err", {31'd0, rsp_err[i]}, {31'd0, sbq[0].err});
                    if (rsp_ready[i]) void'(sbq.pop_front());
                end
            end
            prev_v[i] <= rsp_valid[i] && !rsp_ready[i];
        end
    end

    // Issue one request starting at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rd, input logic exp_err,
                         input bit push, input bit hold, output int acc);
        int   n;
        exp_t e;
        n = 0;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wstrb[i] = wstrb;
        while (!req_ready[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst=%0d actual=ready_low required=ready_high", i);
            req_valid[i] = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (push) begin
                e.inst = i; e.rdata = exp_rd; e.err = exp_err; e.acc = acc;
                sbq.push_back(e);
            end
            @(negedge clk);
            if (!hold) req_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (!req_ready[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {31'd0, req_ready[i]}, 32'd1);
    endtask

    initial begin
        int          acc;
        int          last_acc;
        int          n;
        logic        bwe   [4];
        logic [31:0] baddr [4];
        logic [31:0] bdata [4];
        logic [31:0] bexp  [4];
        bwe   = '{1'b1, 1'b1, 1'b0, 1'b0};
        baddr = '{32'h20, 32'h24, 32'h20, 32'h24};
        bdata = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 32'h0};
        bexp  = '{32'h0, 32'h0, 32'hA0A0A0A0, 32'hB1B1B1B1};

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'h0;
            req_wdata[i] = 32'h0; req_wstrb[i] = 4'h0; rsp_ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
        chk("rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Store then load, errors, boundary index, no wrap of high address
        issue(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h6, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        issue(0, 1'b1, 32'h9, 32'h55, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h80, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        issue(0, 1'b1, 32'hFFFFFFFC, 32'h77, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        issue(0, 1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h7C, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, acc);

        // Response stall
        wait_idle(0);
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, acc);
        repeat (6) @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("req_ready_after_hs", {31'd0, req_ready[0]}, 32'd1);

        // Reset during WAIT of a store: dropped, never written
        issue(0, 1'b1, 32'h10, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata[0], 32'h0);
        chk("midrst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
        chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, acc);

        // Byte strobes
        issue(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b1, 32'h4, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h4, 32'h0, 4'hF, EXP_STRB, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b1, 32'h4, 32'h99999999, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(0, 1'b0, 32'h4, 32'h0, 4'hF, EXP_ZSTRB, 1'b0, 1'b1, 1'b0, acc);

        // Back-to-back with req_valid held, both latencies
        for (int i = 0; i < 2; i++) begin
            wait_idle(i);
            last_acc = 0;
            for (int k = 0; k < 4; k++) begin
                issue(i, bwe[k], baddr[k], bdata[k], 4'hF, bexp[k], 1'b0, 1'b1, (k < 3), acc);
                if (k > 0) chk("b2b_spacing", acc - last_acc, lat_of(i) + 1);
                last_acc = acc;
            end
        end

        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
